// File: rtl/a2_field_split_pipe_if.sv
// Stream bundle for a2_field_split_pipe: input word side and split output side.
// out_parity exists only when A2_FIELD_PARITY_EN is defined.
interface a2_field_split_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] msb_out;
  logic [DATA_W-1:0] lsb_out;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  xfer_cnt;
`ifdef A2_FIELD_PARITY_EN
  logic              out_parity;
`endif

  modport master (
`ifdef A2_FIELD_PARITY_EN
    input  out_parity,
`endif
    output in_data,
    output in_mode,
    output in_valid,
    input  in_ready,
    input  msb_out,
    input  lsb_out,
    input  out_valid,
    output out_ready,
    input  xfer_cnt
  );

  modport slave (
`ifdef A2_FIELD_PARITY_EN
    output out_parity,
`endif
    input  in_data,
    input  in_mode,
    input  in_valid,
    output in_ready,
    output msb_out,
    output lsb_out,
    output out_valid,
    input  out_ready,
    output xfer_cnt
  );
endinterface

// File: rtl/a2_field_split_pipe.sv
// Splits each word into a formatted upper field and masked lower field,
// behind a 1-cycle valid/ready skid pipe. Option macro: A2_FIELD_PARITY_EN.
module a2_field_split_pipe #(
  parameter int DATA_W   = 8,
  parameter int MSB_BITS = 2,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               reset,
  a2_field_split_pipe_if.slave bus
);

  localparam int LO_W = DATA_W - MSB_BITS;
  localparam logic [DATA_W-1:0] MASK =
    {{MSB_BITS{1'b1}}, {LO_W{1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  logic              rdy_q;
  logic              vld_q;
  logic              acc;
  logic              dlv;
  logic              ld_out;
  logic              ld_skid;
  logic              mv_skid;

  logic [MSB_BITS-1:0] fld;
  logic [DATA_W-1:0]   fmt_msb;
  logic [DATA_W-1:0]   fmt_lsb;

  logic [DATA_W-1:0]   msb_q;
  logic [DATA_W-1:0]   lsb_q;
  logic [DATA_W-1:0]   msb_s;
  logic [DATA_W-1:0]   lsb_s;
  logic [CNT_W-1:0]    cnt_q;

  assign acc = bus.in_valid & rdy_q;
  assign dlv = vld_q & bus.out_ready;

  assign fld     = bus.in_data[DATA_W-1 -: MSB_BITS];
  assign fmt_lsb = bus.in_data & ~MASK;

  // Upper-field formatting ahead of the output/skid registers
  always_comb begin
    fmt_msb = '0;
    unique case (bus.in_mode)
      2'b00: fmt_msb = bus.in_data & MASK;
      2'b01: fmt_msb = {{LO_W{1'b0}}, fld};
      2'b10: fmt_msb = {{LO_W{fld[MSB_BITS-1]}}, fld};
      2'b11: fmt_msb = bus.in_data;
    endcase
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next occupancy and register load selects
  always_comb begin
    state_nxt = state_q;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    mv_skid   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          ld_out    = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && !dlv) begin
          ld_skid   = 1'b1;
          state_nxt = SKID;
        end else if (!acc && dlv) begin
          state_nxt = EMPTY;
        end else if (acc && dlv) begin
          ld_out    = 1'b1;
        end
      end
      SKID: begin
        if (dlv) begin
          mv_skid   = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake flags registered from the next occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      rdy_q <= (state_nxt != SKID);
      vld_q <= (state_nxt != EMPTY);
    end
  end

  // Output register: fresh word, or the parked skid word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msb_q <= '0;
      lsb_q <= '0;
    end else if (ld_out) begin
      msb_q <= fmt_msb;
      lsb_q <= fmt_lsb;
    end else if (mv_skid) begin
      msb_q <= msb_s;
      lsb_q <= lsb_s;
    end
  end

  // Skid register catches the word accepted while output is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msb_s <= '0;
      lsb_s <= '0;
    end else if (ld_skid) begin
      msb_s <= fmt_msb;
      lsb_s <= fmt_lsb;
    end
  end

  // Accepted-word counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (acc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef A2_FIELD_PARITY_EN
  logic par_q;
  logic par_s;

  // Parity of the upper field travels with its word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
      par_s <= 1'b0;
    end else begin
      if (ld_out) begin
        par_q <= ^fld;
      end else if (mv_skid) begin
        par_q <= par_s;
      end
      if (ld_skid) begin
        par_s <= ^fld;
      end
    end
  end

  assign bus.out_parity = par_q;
`endif

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.msb_out   = msb_q;
  assign bus.lsb_out   = lsb_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule
